// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle for one elastic pipeline stage: upstream in_*, downstream out_*, and flush.
// slave is the stage's own view; master is the view of whatever drives and sinks it.
interface pipe_stage_reg_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, flush, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register (2-entry skid) with flush/bubble insertion; optional perf counters via PIPE_STAGE_REG_PERF_EN.
// Latency: 1 cycle in_fire -> out_valid; 1 payload/cycle sustained.
// Backpressure: in_ready is decoded from registered state only (low when both entries are full), no path from out_ready.
module pipe_stage_reg #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RST_VAL    = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0] BUBBLE_VAL = {WIDTH{1'b0}},
    parameter int               CNT_W      = 16
) (
    input  logic                clk,
    input  logic                rst,
`ifdef PIPE_STAGE_REG_PERF_EN
    output logic [CNT_W-1:0]    stall_cnt,
    output logic [CNT_W-1:0]    flush_cnt,
`endif
    pipe_stage_reg_if.slave     bus
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_in_fire;
    logic             w_out_fire;

    assign w_in_fire  = bus.in_valid & w_in_ready;
    assign w_out_fire = w_out_valid & bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.flush) begin
            w_state_nxt = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: if (w_in_fire) w_state_nxt = S_ONE;
                S_ONE: begin
                    if (w_in_fire && !w_out_fire)      w_state_nxt = S_TWO;
                    else if (!w_in_fire && w_out_fire) w_state_nxt = S_EMPTY;
                end
                S_TWO:   if (w_out_fire) w_state_nxt = S_ONE;
                default: w_state_nxt = S_EMPTY;
            endcase
        end
    end

    always_comb begin
        w_in_ready  = (r_state != S_TWO);
        w_out_valid = (r_state != S_EMPTY);
    end

    // The main register is the only one visible downstream; skid holds the older-than-input overflow entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_main <= RST_VAL;
            r_skid <= RST_VAL;
        end else if (bus.flush) begin
            r_main <= BUBBLE_VAL;
        end else begin
            case (r_state)
                S_EMPTY: if (w_in_fire) r_main <= bus.in_data;
                S_ONE: begin
                    if (w_in_fire && w_out_fire) r_main <= bus.in_data;
                    else if (w_in_fire)          r_skid <= bus.in_data;
                end
                S_TWO:   if (w_out_fire) r_main <= r_skid;
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = r_main;

`ifdef PIPE_STAGE_REG_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // Saturating counters; conditions are this cycle's pre-update state and inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_out_valid && !bus.out_ready && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (bus.flush && (r_flush_cnt != {CNT_W{1'b1}}))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule
